alu_issue_stage: RTL and testbench

//   ID->EX issue register that feeds the EX-stage ALU.

---
 rtl/alu_issue_stage.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes MIPS op/funct to ALU ctl and registers operands.
// Define ALU_FWD_EN to forward EX/MEM and MEM/WB results into rs/rt at capture.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              flush,
  input  logic              exmem_wen,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wen,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_ctl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_shamt,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic              out_illegal
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;
  localparam logic [2:0] CTL_SLL = 3'b011;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rt_idx;
  logic [REG_AW-1:0] rd_idx;
  logic [15:0]       imm;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign op     = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign rs_idx = REG_AW'(in_instr[25:21]);
  assign rt_idx = REG_AW'(in_instr[20:16]);
  assign rd_idx = REG_AW'(in_instr[15:11]);
  assign imm    = in_instr[15:0];
  assign sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign zext   = {{(DATA_W-16){1'b0}}, imm};

`ifdef ALU_FWD_EN
  always_comb begin
    rs_val = in_rs_data;
    rt_val = in_rt_data;
    // EX/MEM is the younger result, so it wins over MEM/WB
    if (rs_idx != '0 && exmem_wen && exmem_rd == rs_idx)
      rs_val = exmem_data;
    else if (rs_idx != '0 && memwb_wen && memwb_rd == rs_idx)
      rs_val = memwb_data;
    if (rt_idx != '0 && exmem_wen && exmem_rd == rt_idx)
      rt_val = exmem_data;
    else if (rt_idx != '0 && memwb_wen && memwb_rd == rt_idx)
      rt_val = memwb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_wen, exmem_rd, exmem_data,
                        memwb_wen, memwb_rd, memwb_data};
  assign rs_val = in_rs_data;
  assign rt_val = in_rt_data;
`endif

  logic              valid_q, valid_d;
  logic [2:0]        ctl_q, ctl_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wen_q, wen_d;
  logic              ill_q, ill_d;
  logic              capture;

  always_comb begin
    ctl_d   = CTL_ADD;
    a_d     = rs_val;
    b_d     = rt_val;
    shamt_d = in_instr[10:6];
    rd_d    = rt_idx;
    wen_d   = 1'b1;
    ill_d   = 1'b0;
    unique case (op)
      6'h00: begin
        rd_d = rd_idx;
        unique case (funct)
          6'h20: ctl_d = CTL_ADD;
          6'h22: ctl_d = CTL_SUB;
          6'h24: ctl_d = CTL_AND;
          6'h25: ctl_d = CTL_OR;
          6'h2A: ctl_d = CTL_SLT;
          6'h00: begin
            ctl_d = CTL_SLL;
            a_d   = '0;
          end
          default: ill_d = 1'b1;
        endcase
      end
      6'h08: begin ctl_d = CTL_ADD; b_d = sext; end
      6'h0A: begin ctl_d = CTL_SLT; b_d = sext; end
      6'h0C: begin ctl_d = CTL_AND; b_d = zext; end
      6'h0D: begin ctl_d = CTL_OR;  b_d = zext; end
      6'h23: begin ctl_d = CTL_ADD; b_d = sext; end
      6'h2B: begin
        ctl_d = CTL_ADD;
        b_d   = sext;
        wen_d = 1'b0;
      end
      6'h04: begin ctl_d = CTL_SUB; wen_d = 1'b0; end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      ctl_d = CTL_ADD;
      wen_d = 1'b0;
    end
    if (rd_d == '0)
      wen_d = 1'b0;
  end

  // flush keeps in_ready high; the incoming word is dropped anyway
  assign in_ready = !valid_q || out_ready || flush;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush)
      valid_d = 1'b0;
    else if (capture)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_ADD;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        ctl_q   <= ctl_d;
        a_q     <= a_d;
        b_q     <= b_d;
        shamt_q <= shamt_d;
        rd_q    <= rd_d;
        wen_q   <= wen_d;
        ill_q   <= ill_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_ctl     = ctl_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_shamt   = shamt_q;
  assign out_rd      = rd_q;
  assign out_wen     = wen_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: random and directed issue traffic
// checked against a behavioural decode/forwarding model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        flush;
  logic        exmem_wen;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        memwb_wen;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_shamt;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .flush(flush),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data),
    .memwb_wen(memwb_wen), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctl(out_ctl), .out_a(out_a), .out_b(out_b),
    .out_shamt(out_shamt), .out_rd(out_rd),
    .out_wen(out_wen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src(
      input logic [4:0] idx, input logic [31:0] raw,
      input logic ew, input logic [4:0] er, input logic [31:0] ed,
      input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    logic [31:0] v;
    v = raw;
`ifdef ALU_FWD_EN
    if (idx != 0 && ww && wr == idx) v = wd;
    if (idx != 0 && ew && er == idx) v = ed;
`else
    if (ew && ww && er == wr && ed == wd && idx == 5'd31) v = raw;
`endif
    return v;
  endfunction

  function automatic exp_t model(
      input logic [31:0] ins, input logic [31:0] rsd,
      input logic [31:0] rtd,
      input logic ew, input logic [4:0] er, input logic [31:0] ed,
      input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    exp_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] sx;
    logic [31:0] zx;
    op  = ins[31:26];
    fn  = ins[5:0];
    rsv = src(ins[25:21], rsd, ew, er, ed, ww, wr, wd);
    rtv = src(ins[20:16], rtd, ew, er, ed, ww, wr, wd);
    sx  = 32'($signed(ins[15:0]));
    zx  = 32'(ins[15:0]);
    e.shamt = ins[10:6];
    e.a = rsv; e.b = rtv; e.rd = ins[20:16];
    e.ctl = 3'b010; e.wen = 1'b1; e.ill = 1'b0;
    if (op == 6'h00) begin
      e.rd = ins[15:11];
      case (fn)
        6'h20: e.ctl = 3'b010;
        6'h22: e.ctl = 3'b110;
        6'h24: e.ctl = 3'b000;
        6'h25: e.ctl = 3'b001;
        6'h2A: e.ctl = 3'b111;
        6'h00: begin e.ctl = 3'b011; e.a = 0; end
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08: begin e.ctl = 3'b010; e.b = sx; end
        6'h0A: begin e.ctl = 3'b111; e.b = sx; end
        6'h0C: begin e.ctl = 3'b000; e.b = zx; end
        6'h0D: begin e.ctl = 3'b001; e.b = zx; end
        6'h23: begin e.ctl = 3'b010; e.b = sx; end
        6'h2B: begin e.ctl = 3'b010; e.b = sx; e.wen = 0; end
        6'h04: begin e.ctl = 3'b110; e.wen = 0; end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) e.wen = 1'b0;
    if (e.rd == 0) e.wen = 1'b0;
    return e;
  endfunction

  // Monitor: front of queue must be on the outputs while valid
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready),
          32'(q.size() == 0 || out_ready || flush));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("ctl", 32'(out_ctl), 32'(q[0].ctl));
        chk("a", out_a, q[0].a);
        chk("b", out_b, q[0].b);
        chk("shamt", 32'(out_shamt), 32'(q[0].shamt));
        chk("rd", 32'(out_rd), 32'(q[0].rd));
        chk("wen", 32'(out_wen), 32'(q[0].wen));
        chk("illegal", 32'(out_illegal), 32'(q[0].ill));
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input logic v, input logic rdy, input logic fl,
      input logic [31:0] ins, input logic [31:0] rsd,
      input logic [31:0] rtd,
      input logic ew, input logic [4:0] er, input logic [31:0] ed,
      input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    in_valid = v; out_ready = rdy; flush = fl;
    in_instr = ins; in_rs_data = rsd; in_rt_data = rtd;
    exmem_wen = ew; exmem_rd = er; exmem_data = ed;
    memwb_wen = ww; memwb_rd = wr; memwb_data = wd;
    @(posedge clk);
    if (v && !fl && q.size() == 0)
      q.push_back(model(ins, rsd, rtd, ew, er, ed, ww, wr, wd));
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rsd,
                       input logic [31:0] rtd);
    cyc(1, 0, 0, ins, rsd, rtd, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input logic rdy);
    cyc(0, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] gen();
    logic [5:0] op;
    logic [5:0] fn;
    case ($urandom_range(0, 9))
      0, 1, 2: op = 6'h00;
      3: op = 6'h08;
      4: op = 6'h0A;
      5: op = 6'h0C;
      6: op = 6'h0D;
      7: op = 6'h23;
      8: op = ($urandom_range(0, 1) != 0) ? 6'h2B : 6'h04;
      default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 6))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      5: fn = 6'h00;
      default: fn = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom), fn};
  endfunction

  task automatic rnd(input int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 9) == 0, gen(), $urandom, $urandom,
          1'($urandom), 5'($urandom_range(0, 3)), $urandom,
          1'($urandom), 5'($urandom_range(0, 3)), $urandom);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; out_ready = 0; flush = 0; in_instr = 0;
    in_rs_data = 0; in_rt_data = 0;
    exmem_wen = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wen = 0; memwb_rd = 0; memwb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ctl", 32'(out_ctl), 32'h2);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_shamt", 32'(out_shamt), 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_wen", 32'(out_wen), 0);
    chk("rst_illegal", 32'(out_illegal), 0);
    rst = 1'b0;
    idle(1);

    // add $3,$1,$2
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 5, 7);
    idle(0);
    chk("add_ctl", 32'(out_ctl), 32'h2);
    chk("add_a", out_a, 5);
    chk("add_b", out_b, 7);
    chk("add_rd", 32'(out_rd), 3);
    chk("add_wen", 32'(out_wen), 1);
    idle(1);
    // sll $4,$2,3
    issue({6'h00, 5'd0, 5'd2, 5'd4, 5'd3, 6'h00}, 9, 7);
    idle(0);
    chk("sll_ctl", 32'(out_ctl), 32'h3);
    chk("sll_a", out_a, 0);
    chk("sll_b", out_b, 7);
    chk("sll_shamt", 32'(out_shamt), 3);
    idle(1);
    // slti $5,$1,-1
    issue({6'h0A, 5'd1, 5'd5, 16'hFFFF}, 1, 2);
    idle(0);
    chk("slti_ctl", 32'(out_ctl), 32'h7);
    chk("slti_b", out_b, 32'hFFFF_FFFF);
    idle(1);
    // ori $5,$1,0x8000
    issue({6'h0D, 5'd1, 5'd5, 16'h8000}, 1, 2);
    idle(0);
    chk("ori_b", out_b, 32'h0000_8000);
    idle(1);
    issue(32'hFC00_0000, 1, 2);
    idle(0);
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_wen", 32'(out_wen), 0);
    idle(1);
    issue({6'h2B, 5'd1, 5'd2, 16'h0004}, 1, 2);
    idle(0);
    chk("sw_wen", 32'(out_wen), 0);
    idle(1);
    issue({6'h08, 5'd1, 5'd0, 16'h0005}, 1, 2);
    idle(0);
    chk("addi0_wen", 32'(out_wen), 0);
    idle(1);

`ifdef ALU_FWD_EN
    cyc(1, 0, 0, {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20}, 32'h11, 32'h22,
        1, 5'd2, 32'hAA, 1, 5'd2, 32'hBB);
    idle(0);
    chk("fwd_exmem", out_a, 32'hAA);
    idle(1);
    cyc(1, 0, 0, {6'h00, 5'd0, 5'd1, 5'd3, 5'd0, 6'h20}, 32'h11, 32'h22,
        1, 5'd0, 32'hAA, 0, 5'd0, 32'hBB);
    idle(0);
    chk("fwd_r0", out_a, 32'h11);
    idle(1);
`endif

    // backpressure: held word stays, next one waits
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 40, 2);
    for (int i = 0; i < 3; i++) begin
      issue({6'h08, 5'd1, 5'd6, 16'h0010}, 100, 0);
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_frozen_a", out_a, 40);
    end
    cyc(1, 1, 0, {6'h08, 5'd1, 5'd6, 16'h0010}, 100, 0,
        0, 0, 0, 0, 0, 0);
    chk("bp_next_b", out_b, 32'h10);
    idle(1);
    idle(1);

    // flush drops held and incoming
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 1, 2);
    cyc(1, 0, 1, {6'h0C, 5'd1, 5'd7, 16'h00FF}, 3, 4,
        0, 0, 0, 0, 0, 0);
    chk("flush_valid", 32'(out_valid), 0);
    idle(1);
    chk("flush_gone", 32'(out_valid), 0);

    rnd(300);

    // reset in the middle of traffic
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, 1, 2);
    in_valid = 0;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ctl", 32'(out_ctl), 32'h2);
    chk("arst_wen", 32'(out_wen), 0);
    repeat (2) @(posedge clk);
    q.delete();
    #1;
    rst = 1'b0;
    idle(1);

    rnd(300);
    for (int i = 0; i < 5; i++) idle(1);
    chk("drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
